// File: rtl/edge_detect_pkg.sv
// Shared mode encodings and width helpers for the multi-channel
// edge detector.
package edge_detect_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bits needed to hold values 0..n, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One edge-detect channel: synchroniser, previous-value register,
// mode-gated detector, pulse stretcher and sticky flag.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_i,
    input  logic [1:0] mode_i,
    input  logic       en_i,
    input  logic       clr_i,
    output logic       det_o,
    output logic       pulse_o,
    output logic       sticky_o
);

    localparam int SW = cnt_width(PULSE_LEN);
    localparam logic [SW-1:0] RELOAD = SW'(PULSE_LEN);

    logic          s;
    logic          prev_q;
    logic          prev_d;
    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;
    logic          sticky_q;
    logic          sticky_d;
    logic          rise;
    logic          fall;
    logic          det;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = din_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= din_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    // Priming gate comes from the top so all channels open together.
    always_comb begin
        det = 1'b0;
        unique case (mode_i)
            EDGE_OFF:  det = 1'b0;
            EDGE_RISE: det = rise;
            EDGE_FALL: det = fall;
            EDGE_BOTH: det = rise | fall;
            default:   det = 1'b0;
        endcase
        if (!en_i) begin
            det = 1'b0;
        end
    end

    always_comb begin
        prev_d   = s;
        cnt_d    = cnt_q;
        sticky_d = det | (sticky_q & ~clr_i);
        if (det) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign det_o    = det;
    assign pulse_o  = (cnt_q != '0);
    assign sticky_o = sticky_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector top: channel array, shared priming
// counter, registered any-edge flag and saturating event counter.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] edge_pulse,
    output logic [WIDTH-1:0] edge_sticky,
    output logic             edge_any,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int PRIME_N = SYNC_STAGES + 1;
    localparam int PW      = cnt_width(PRIME_N);
    localparam logic [PW-1:0] PRIME_END = PW'(PRIME_N);

    logic [PW-1:0]    prime_q;
    logic [PW-1:0]    prime_d;
    logic             primed;
    logic [WIDTH-1:0] det;
    logic             any_q;
    logic             any_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Detection opens once the sync chain and prev hold post-reset data.
    assign primed = (prime_q == PRIME_END);

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_chan
            edge_detect_chan #(
                .SYNC_STAGES(SYNC_STAGES),
                .PULSE_LEN  (PULSE_LEN)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .din_i   (din[g]),
                .mode_i  (mode),
                .en_i    (primed),
                .clr_i   (clr[g]),
                .det_o   (det[g]),
                .pulse_o (edge_pulse[g]),
                .sticky_o(edge_sticky[g])
            );
        end
    endgenerate

    always_comb begin
        prime_d = primed ? prime_q : prime_q + PW'(1);
        any_d   = |det;
        cnt_d   = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (any_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_q <= '0;
            any_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prime_q <= prime_d;
            any_q   <= any_d;
            cnt_q   <= cnt_d;
        end
    end

    assign edge_any = any_q;
    assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomised scoreboard bench for edge_detect_multi against a
// sample-history reference model.
module tb_edge_detect_multi;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int PL   = 4;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din;
    logic [1:0]    mode;
    logic [W-1:0]  clr;
    logic          cnt_clr;
    logic [W-1:0]  edge_pulse;
    logic [W-1:0]  edge_sticky;
    logic          edge_any;
    logic [CW-1:0] edge_cnt;

    always #5 clk = ~clk;

    edge_detect_multi #(
        .WIDTH      (W),
        .SYNC_STAGES(S),
        .PULSE_LEN  (PL),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .mode       (mode),
        .clr        (clr),
        .cnt_clr    (cnt_clr),
        .edge_pulse (edge_pulse),
        .edge_sticky(edge_sticky),
        .edge_any   (edge_any),
        .edge_cnt   (edge_cnt)
    );

    typedef struct packed {
        logic [W-1:0]  pulse;
        logic [W-1:0]  sticky;
        logic          any;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   armed  = 1'b0;

    // Reference state: every din sample since reset release.
    logic [W-1:0] hist[$];
    int           k;
    int           last_det[W];
    logic [W-1:0] m_sticky;
    int           m_cnt;

    task automatic model_edge(output exp_t e);
        logic [W-1:0] cur;
        logic [W-1:0] old;
        logic [W-1:0] det;
        e = '0;
        if (rst) begin
            hist.delete();
            k = 0;
            for (int i = 0; i < W; i++) last_det[i] = -1000;
            m_sticky = '0;
            m_cnt = 0;
            return;
        end
        hist.push_back(din);
        k = k + 1;
        det = '0;
        // Sync output seen at edge k is the sample taken at edge k-S.
        if (k >= S + 2) begin
            cur = hist[k-S-1];
            old = hist[k-S-2];
            if (mode[0]) det = det | (cur & ~old);
            if (mode[1]) det = det | (~cur & old);
        end
        for (int i = 0; i < W; i++) begin
            if (det[i]) last_det[i] = k;
            e.pulse[i] = ((k - last_det[i]) < PL);
        end
        m_sticky = det | (m_sticky & ~clr);
        if (cnt_clr) m_cnt = 0;
        else if ((det != '0) && (m_cnt < CMAX)) m_cnt = m_cnt + 1;
        e.sticky = m_sticky;
        e.any    = (det != '0);
        e.cnt    = CW'(m_cnt);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one output set per clock, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("edge_pulse", int'(edge_pulse), int'(e.pulse));
                    chk("edge_sticky", int'(edge_sticky), int'(e.sticky));
                    chk("edge_any", int'(edge_any), int'(e.any));
                    chk("edge_cnt", int'(edge_cnt), int'(e.cnt));
                end
            end
        end
    end

    // Driver: set inputs mid-cycle, push the expected post-edge outputs.
    initial begin
        exp_t e;
        logic [W-1:0] tog;
        rst     = 1'b1;
        din     = '1;
        mode    = 2'b11;
        clr     = '0;
        cnt_clr = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            clr     = '0;
            cnt_clr = 1'b0;
            if (c < 3) begin
                rst  = 1'b1;
                din  = '1;
                mode = 2'b11;
            end else if (c < 40) begin
                rst = 1'b0;
                if (c == 20) din[3] = 1'b0;
                if (c == 30) clr = 8'h08;
            end else begin
                rst = ($urandom_range(0, 299) == 0);
                if ((c % 50) == 0) mode = 2'($urandom);
                case ((c / 100) % 3)
                    0: tog = W'($urandom & $urandom & $urandom);
                    1: tog = W'($urandom);
                    default: tog = W'($urandom & $urandom);
                endcase
                din     = din ^ tog;
                clr     = W'($urandom & $urandom & $urandom & $urandom);
                cnt_clr = ($urandom_range(0, 39) == 0);
            end
            model_edge(e);
            sb.push_back(e);
            armed = 1'b1;
        end
        @(posedge clk);
        #2;
        armed = 1'b0;
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
